result_collector: RTL
=====================

# result_collector

Receiving end of the systolic array's data path. It accepts the array's skewed output lanes, deskews them into whole rows, and writes each row into a MATRIX_SIZE×MATRIX_SIZE result memory in row-major order. It then raises `done` and exposes the memory through a registered read port. It is the counterpart of the row fetcher that feeds the array.

## Interface
- `MATRIX_SIZE`, 2: lanes per row and rows per matrix (M).
- `DATA_SIZE`, 32: element width in bits.
- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: low acts as a synchronous soft reset of control state; memory is retained.
- `clear`  in  1: synchronous one-cycle pulse that rearms the collector for a new matrix.
- `in_valid`  in  1: marks lane 0 of a new row in this cycle.
- `data_in`  in  [DATA_SIZE-1:0] × M (unpacked array): lane j carries its element of a row j cycles after that row's `in_valid`.
- `rd_addr`  in  $clog2(M*M): read address, row*M + lane.
- `rd_data`  out  DATA_SIZE: registered read data.
- `row_count`  out  $clog2(M)+1: number of rows written.
- `done`  out  1: all M rows written.
- `overflow`  out  1: sticky; set when `in_valid` is asserted while in DONE.

## Operation
- Deskew: lane j is delayed by M-1-j registers, and `in_valid` is delayed by M-1 registers. When the delayed valid is high, all M deskewed lanes form one row.
- Row write: `mem[row_count*M + j]` ← deskewed lane j for every j, and `row_count` increments, both on the same edge.
- FSM, encoded as states IDLE, COLLECT and DONE:
  - IDLE → COLLECT on `in_valid`.
  - COLLECT → DONE on the edge that writes row M-1.
  - DONE → IDLE on `clear`.
  - Any state → IDLE on `reset`, `!enable` or `clear`.
- Rows may arrive with any spacing ≥ 1 cycle, including `in_valid` on consecutive cycles. The pipeline accepts a new row every cycle.
- In DONE, `in_valid` sets `overflow`. The row is dropped: no memory write and no `row_count` change.
- `clear`, `!enable` and `reset` each do the following:
  - zero `row_count`, `done` and `overflow`;
  - flush the deskew delay lines, so in-flight rows are discarded and never written.
- `clear` and `!enable` leave memory untouched. `reset` additionally zeroes all memory entries and `rd_data`.
- Priority: `reset` > `!enable` > `clear` > row write > `in_valid` capture. If `clear` and `in_valid` arrive in the same cycle, that row is dropped.
- Arithmetic:
  - The write address is computed at full `rd_addr` width.
  - `row_count` saturates at M; it never wraps, because writes stop in DONE.
  - Data is stored unmodified, with no width conversion.

## Timing
- Reset values: `rd_data`=0, `row_count`=0, `done`=0, `overflow`=0, state IDLE, all memory entries 0.
- Row whose `in_valid` is in cycle t:
  - written on the edge ending cycle t+M-1;
  - visible through the read port when `rd_addr` is applied in cycle t+M or later;
  - `row_count` shows the new value from cycle t+M.
- `done` goes high in the cycle after the final row's write, through the same edge as `row_count`, and stays high until `clear`, `!enable` or `reset`.
- `overflow` goes high in the cycle after the offending `in_valid`.
- Read latency is 1 cycle: `rd_data` in cycle n+1 equals `mem[rd_addr]` sampled at the end of cycle n. A read of an address written on the same edge returns the old value.
- `rd_data` is independent of state and remains valid during COLLECT and DONE.

## Test plan
All scenarios use M=2, DATA_SIZE=32.
1. Reset: assert `reset` for 2 cycles, then release → `rd_data`=0, `row_count`=0, `done`=0, `overflow`=0; reading addresses 0..3 returns 0.
2. Spaced rows, with 2 cycles from row to row:
   - Stimulus: c0 `in_valid`, lane0=5; c1 lane1=6; c2 `in_valid`, lane0=7; c3 lane1=8.
   - Response: `row_count`=1 in c2 and 2 in c4; `done`=1 from c4.
   - Readback: `rd_addr` 0..3 in c5..c8 yields 5, 6, 7, 8 in c6..c9.
3. Back-to-back rows:
   - Stimulus: `in_valid` in c0 and c1; c0 lane0=1; c1 lane0=3, lane1=2; c2 lane1=4.
   - Response: memory holds 1, 2, 3, 4; `done`=1 from c3.
4. Overflow: after scenario 2, pulse `in_valid` with lane0=9 → `overflow`=1 next cycle; `row_count` stays 2; memory unchanged at 5, 6, 7, 8.
5. Clear mid-matrix:
   - Stimulus: write row 0 (lanes 5, 6), pulse `clear`, then send rows (1, 2) and (3, 4).
   - Response: memory holds 1, 2, 3, 4; `done`=1; `overflow`=0.
6. Enable drop in flight: `in_valid` with lane0=7 in c0, `enable`=0 in c1 with lane1=8, `enable`=1 from c2 → no write; `row_count`=0; memory holds prior contents; state IDLE.

Source files
------------

// File: rtl/result_collector.sv
// Deskews the systolic array's skewed output lanes into whole rows and stores
// them row-major in an MxM result memory exposed through a registered read port.
module result_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic                                       i_enable,
  input  logic                                       i_clear,
  input  logic                                       i_in_valid,
  input  logic [DATA_SIZE-1:0]                       i_data_in [MATRIX_SIZE],
  input  logic [$clog2(MATRIX_SIZE*MATRIX_SIZE)-1:0] i_rd_addr,
  output logic [DATA_SIZE-1:0]                       o_rd_data,
  output logic [$clog2(MATRIX_SIZE):0]               o_row_count,
  output logic                                       o_done,
  output logic                                       o_overflow
);

  localparam int AW    = $clog2(MATRIX_SIZE*MATRIX_SIZE);
  localparam int RCW   = $clog2(MATRIX_SIZE) + 1;
  localparam int DEPTH = MATRIX_SIZE * MATRIX_SIZE;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [RCW-1:0]       r_row_count;
  logic                 r_done;
  logic                 r_overflow;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rd_data;

  logic                 w_flush;
  logic                 w_vld_in;
  logic                 w_vld_out;
  logic                 w_wr_en;
  logic                 w_last_row;
  logic [AW-1:0]        w_wr_base;
  logic [DATA_SIZE-1:0] w_lane [MATRIX_SIZE];

  // In-flight rows are discarded by any of reset, enable drop or clear.
  assign w_flush    = i_reset || !i_enable || i_clear;
  assign w_vld_in   = i_in_valid && (r_state != S_DONE);
  assign w_last_row = (r_row_count == RCW'(MATRIX_SIZE - 1));
  assign w_wr_en    = w_vld_out && !w_flush && (r_state == S_COLLECT)
                      && (r_row_count < RCW'(MATRIX_SIZE));
  assign w_wr_base  = AW'(r_row_count) * AW'(MATRIX_SIZE);

  generate
    if (MATRIX_SIZE > 1) begin : g_vld_dly
      logic r_vld_sr [MATRIX_SIZE-1];

      // Valid delay line of M-1 stages, aligned with the deskewed lanes.
      always_ff @(posedge i_clk) begin
        if (w_flush) begin
          for (int k = 0; k < MATRIX_SIZE-1; k++) r_vld_sr[k] <= 1'b0;
        end else begin
          r_vld_sr[0] <= w_vld_in;
          for (int k = 1; k < MATRIX_SIZE-1; k++) r_vld_sr[k] <= r_vld_sr[k-1];
        end
      end

      assign w_vld_out = r_vld_sr[MATRIX_SIZE-2];
    end else begin : g_vld_pass
      assign w_vld_out = w_vld_in;
    end

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
      localparam int D = MATRIX_SIZE - 1 - j;
      if (D > 0) begin : g_dly
        logic [DATA_SIZE-1:0] r_sr [D];

        // Lane j arrives j cycles late, so it waits M-1-j more stages.
        always_ff @(posedge i_clk) begin
          if (w_flush) begin
            for (int k = 0; k < D; k++) r_sr[k] <= '0;
          end else begin
            r_sr[0] <= i_data_in[j];
            for (int k = 1; k < D; k++) r_sr[k] <= r_sr[k-1];
          end
        end

        assign w_lane[j] = r_sr[D-1];
      end else begin : g_pass
        assign w_lane[j] = i_data_in[j];
      end
    end
  endgenerate

  // Next-state logic for the collection FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) w_state_nxt = S_COLLECT;
        else            w_state_nxt = S_IDLE;
      end
      S_COLLECT: begin
        if (w_wr_en && w_last_row) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_COLLECT;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, row counter and status flags.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_enable || i_clear) begin
      r_state     <= S_IDLE;
      r_row_count <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) begin
        r_row_count <= r_row_count + RCW'(1);
        if (w_last_row) r_done <= 1'b1;
        else            r_done <= r_done;
      end else begin
        r_row_count <= r_row_count;
        r_done      <= r_done;
      end
      if ((r_state == S_DONE) && i_in_valid) r_overflow <= 1'b1;
      else                                   r_overflow <= r_overflow;
    end
  end

  // Result memory and registered read port; only reset clears contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_en) begin
        for (int j = 0; j < MATRIX_SIZE; j++) r_mem[w_wr_base + AW'(j)] <= w_lane[j];
      end
      if (int'(i_rd_addr) < DEPTH) r_rd_data <= r_mem[i_rd_addr];
      else                         r_rd_data <= '0;
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_row_count = r_row_count;
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;

endmodule
